// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light controller pins: rebuilds the
// controller phase from lamp/segment samples and raises sticky violation flags.
module traffic_light_monitor #(
    parameter int unsigned T_RED         = 9,
    parameter int unsigned T_RED_YELLOW  = 3,
    parameter int unsigned T_GREEN       = 9,
    parameter int unsigned T_GREEN_BLINK = 5,
    parameter int unsigned T_YELLOW      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lamp_r,
    input  logic       lamp_y,
    input  logic       lamp_g,
    input  logic [6:0] seg,
    input  logic       clr_err,
    output logic [2:0] phase,
    output logic [3:0] digit,
    output logic       seg_valid,
    output logic [4:0] err_flags,
    output logic       err_irq,
    output logic [7:0] cycles
);

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_RED    = 3'd1,
        PH_RY     = 3'd2,
        PH_GREEN  = 3'd3,
        PH_GB     = 3'd4,
        PH_YELLOW = 3'd5,
        PH_UNSYNC = 3'd7
    } phase_t;

    phase_t     phase_r, next_phase_s, adv_phase_s;
    logic [3:0] idx_r, next_idx_s;
    logic       first_red_r, next_first_red_s;
    logic       resync_r, next_resync_s;
    logic       dur_flag_r, next_dur_flag_s;
    logic       prev_blink_r;
    logic       is_r_s, is_ry_s, is_g_s, is_y_s, is_dark_s, illegal_s;
    logic       hold_s, adv_s, seq_err_s, changed_s, timed_s;
    logic       exit_err_s, stay_err_s, blink_err_s, disp_err_s, dig_chk_s;
    logic [4:0] t_cur_s, new_err_s, dec_s;
    logic [7:0] exp_digit_s;

    // Returns {valid, digit} for a segment pattern (bit0 = a ... bit6 = g).
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0111111: return {1'b1, 4'd0};
            7'b0000110: return {1'b1, 4'd1};
            7'b1011011: return {1'b1, 4'd2};
            7'b1001111: return {1'b1, 4'd3};
            7'b1100110: return {1'b1, 4'd4};
            7'b1101101: return {1'b1, 4'd5};
            7'b1111101: return {1'b1, 4'd6};
            7'b0000111: return {1'b1, 4'd7};
            7'b1111111: return {1'b1, 4'd8};
            7'b1101111: return {1'b1, 4'd9};
            default:    return {1'b0, 4'd0};
        endcase
    endfunction

    assign phase = phase_r;

    // Phase reconstruction and all per-sample protocol checks.
    always_comb begin
        is_r_s    = lamp_r & ~lamp_y & ~lamp_g;
        is_ry_s   = lamp_r &  lamp_y & ~lamp_g;
        is_g_s    = ~lamp_r & ~lamp_y & lamp_g;
        is_y_s    = ~lamp_r &  lamp_y & ~lamp_g;
        is_dark_s = ~lamp_r & ~lamp_y & ~lamp_g;
        illegal_s = lamp_g & (lamp_r | lamp_y);

        hold_s      = 1'b0;
        adv_s       = 1'b0;
        adv_phase_s = PH_UNSYNC;
        t_cur_s     = 5'd0;
        case (phase_r)
            PH_IDLE:   begin hold_s = is_y_s | is_dark_s; adv_s = is_r_s;  adv_phase_s = PH_RED; end
            PH_RED:    begin hold_s = is_r_s;  adv_s = is_ry_s;   adv_phase_s = PH_RY;     t_cur_s = 5'(T_RED); end
            PH_RY:     begin hold_s = is_ry_s; adv_s = is_g_s;    adv_phase_s = PH_GREEN;  t_cur_s = 5'(T_RED_YELLOW); end
            PH_GREEN:  begin hold_s = is_g_s;  adv_s = is_dark_s; adv_phase_s = PH_GB;     t_cur_s = 5'(T_GREEN); end
            PH_GB:     begin hold_s = is_g_s | is_dark_s; adv_s = is_y_s; adv_phase_s = PH_YELLOW; t_cur_s = 5'(T_GREEN_BLINK); end
            PH_YELLOW: begin hold_s = is_y_s;  adv_s = is_r_s;    adv_phase_s = PH_RED;    t_cur_s = 5'(T_YELLOW); end
            PH_UNSYNC: begin
                hold_s = is_dark_s;
                adv_s  = is_r_s | is_ry_s | is_g_s | is_y_s;
                if (is_r_s)       adv_phase_s = PH_RED;
                else if (is_ry_s) adv_phase_s = PH_RY;
                else if (is_g_s)  adv_phase_s = PH_GREEN;
                else              adv_phase_s = PH_YELLOW;
            end
            default:   begin hold_s = 1'b0; adv_s = 1'b1; adv_phase_s = PH_UNSYNC; end
        endcase

        seq_err_s = 1'b0;
        if (illegal_s) begin
            next_phase_s = PH_UNSYNC;
        end else if (hold_s) begin
            next_phase_s = phase_r;
        end else if (adv_s) begin
            next_phase_s = adv_phase_s;
        end else begin
            next_phase_s = PH_UNSYNC;
            seq_err_s    = 1'b1;
        end

        changed_s = (next_phase_s != phase_r);
        timed_s   = (phase_r != PH_IDLE) && (phase_r != PH_UNSYNC) && !resync_r && !dur_flag_r;
        if (changed_s)            next_idx_s = 4'd0;
        else if (idx_r == 4'd15)  next_idx_s = 4'd15;
        else                      next_idx_s = idx_r + 4'd1;

        // The first RED after reset may be short: the controller's counter carries over.
        exit_err_s = 1'b0;
        stay_err_s = 1'b0;
        if (timed_s && !illegal_s && !hold_s && adv_s) begin
            if (first_red_r && (phase_r == PH_RED)) exit_err_s = ({1'b0, idx_r} > t_cur_s);
            else                                    exit_err_s = ({1'b0, idx_r} != t_cur_s);
        end else if (timed_s && !changed_s) begin
            stay_err_s = ({1'b0, next_idx_s} > t_cur_s);
        end else begin
            stay_err_s = 1'b0;
        end

        next_dur_flag_s  = changed_s ? 1'b0 : (dur_flag_r | stay_err_s);
        next_first_red_s = (changed_s && (phase_r == PH_RED)) ? 1'b0 : first_red_r;
        next_resync_s    = changed_s ? (phase_r == PH_UNSYNC) : resync_r;

        if (next_phase_s == PH_IDLE)    blink_err_s = (lamp_y == prev_blink_r);
        else if (next_phase_s == PH_GB) blink_err_s = changed_s ? lamp_g : (lamp_g == prev_blink_r);
        else                            blink_err_s = 1'b0;

        dec_s       = seg_decode(seg);
        dig_chk_s   = (next_phase_s != PH_UNSYNC) && !next_resync_s &&
                      !((next_phase_s == PH_RED) && next_first_red_s);
        exp_digit_s = (next_phase_s == PH_RED) ? (8'(T_RED) - {4'd0, next_idx_s}) : 8'd0;
        disp_err_s  = !dec_s[4] || (dig_chk_s && (exp_digit_s != {4'd0, dec_s[3:0]}));

        new_err_s = {disp_err_s, blink_err_s, exit_err_s | stay_err_s, seq_err_s, illegal_s};
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r      <= PH_IDLE;
            idx_r        <= 4'd0;
            first_red_r  <= 1'b1;
            resync_r     <= 1'b0;
            dur_flag_r   <= 1'b0;
            prev_blink_r <= 1'b1;
            digit        <= 4'd0;
            seg_valid    <= 1'b0;
            err_flags    <= 5'd0;
            err_irq      <= 1'b0;
            cycles       <= 8'd0;
        end else begin
            phase_r      <= next_phase_s;
            idx_r        <= next_idx_s;
            first_red_r  <= next_first_red_s;
            resync_r     <= next_resync_s;
            dur_flag_r   <= next_dur_flag_s;
            prev_blink_r <= (next_phase_s == PH_IDLE) ? lamp_y : lamp_g;
            if (dec_s[4]) digit <= dec_s[3:0];
            else          digit <= digit;
            seg_valid    <= dec_s[4];
            err_flags    <= (clr_err ? 5'd0 : err_flags) | new_err_s;
            err_irq      <= |new_err_s;
            if ((phase_r == PH_YELLOW) && (next_phase_s == PH_RED)) cycles <= cycles + 8'd1;
            else                                                     cycles <= cycles;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor with default timing.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lamp_r = 1'b0, lamp_y = 1'b0, lamp_g = 1'b0;
    logic [6:0] seg = 7'd0;
    logic       clr_err = 1'b0;
    logic [2:0] phase;
    logic [3:0] digit;
    logic       seg_valid;
    logic [4:0] err_flags;
    logic       err_irq;
    logic [7:0] cycles;

    int tests_run = 0;
    int tests_failed = 0;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
        .seg(seg), .clr_err(clr_err), .phase(phase), .digit(digit),
        .seg_valid(seg_valid), .err_flags(err_flags), .err_irq(err_irq), .cycles(cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // One sample: drive pins, let the edge take them, look 1 time unit later.
    task automatic send(input logic r, input logic y, input logic g, input logic [6:0] s);
        lamp_r = r; lamp_y = y; lamp_g = g; seg = s;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic r, input logic y, input logic g, input int n);
        for (int i = 0; i < n; i++) send(r, y, g, seg_of(0));
    endtask

    task automatic red_count(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'b0, seg_of(9 - i));
    endtask

    task automatic blink(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, i[0], seg_of(0));
    endtask

    task automatic tail();
        hold(1'b1, 1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 1'b1, 10);
        blink(6);
        hold(1'b0, 1'b1, 1'b0, 4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({phase, digit, seg_valid, err_flags, err_irq, cycles} !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got ph=%0d dig=%0d sv=%b err=%b irq=%b cyc=%0d, want all 0",
                     phase, digit, seg_valid, err_flags, err_irq, cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        logic [2:0] ph_exp [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
        for (int i = 0; i < 7; i++) begin
            send(1'b0, i[0], 1'b0, seg_of(0));
            tests_run++;
            if ({phase, err_flags} !== {3'd0, 5'd0}) begin
                tests_failed++;
                $display("FAIL nominal_idle[%0d]: got ph=%0d err=%b, want ph=0 err=00000", i, phase, err_flags);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0, 1'b0, seg_of(6 + i));
            tests_run++;
            if ({phase, err_flags, digit} !== {3'd1, 5'd0, 4'(6 + i)}) begin
                tests_failed++;
                $display("FAIL nominal_first_red[%0d]: got ph=%0d err=%b dig=%0d, want ph=1 err=00000 dig=%0d",
                         i, phase, err_flags, digit, 6 + i);
            end
        end
        hold(1'b1, 1'b1, 1'b0, 4);
        tests_run++;
        if ({phase, err_flags} !== {ph_exp[0], 5'd0}) begin
            tests_failed++;
            $display("FAIL nominal_ry: got ph=%0d err=%b, want ph=2 err=00000", phase, err_flags);
        end
        hold(1'b0, 1'b0, 1'b1, 10);
        tests_run++;
        if ({phase, err_flags} !== {ph_exp[1], 5'd0}) begin
            tests_failed++;
            $display("FAIL nominal_green: got ph=%0d err=%b, want ph=3 err=00000", phase, err_flags);
        end
        blink(6);
        tests_run++;
        if ({phase, err_flags} !== {ph_exp[2], 5'd0}) begin
            tests_failed++;
            $display("FAIL nominal_gblink: got ph=%0d err=%b, want ph=4 err=00000", phase, err_flags);
        end
        hold(1'b0, 1'b1, 1'b0, 4);
        tests_run++;
        if ({phase, err_flags, cycles} !== {ph_exp[3], 5'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL nominal_yellow: got ph=%0d err=%b cyc=%0d, want ph=5 err=00000 cyc=0",
                     phase, err_flags, cycles);
        end
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 1'b0, 1'b0, seg_of(9 - i));
            tests_run++;
            if ({phase, err_flags, digit, seg_valid, cycles} !== {ph_exp[4], 5'd0, 4'(9 - i), 1'b1, 8'd1}) begin
                tests_failed++;
                $display("FAIL nominal_red[%0d]: got ph=%0d err=%b dig=%0d sv=%b cyc=%0d, want ph=1 err=00000 dig=%0d sv=1 cyc=1",
                         i, phase, err_flags, digit, seg_valid, cycles, 9 - i);
            end
        end
    endtask

    task automatic test_lamp_combo();
        hold(1'b1, 1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 1'b1, 3);
        send(1'b1, 1'b0, 1'b1, seg_of(0));
        tests_run++;
        if ({phase, err_flags, err_irq} !== {3'd7, 5'b00001, 1'b1}) begin
            tests_failed++;
            $display("FAIL lamp_combo: got ph=%0d err=%b irq=%b, want ph=7 err=00001 irq=1", phase, err_flags, err_irq);
        end
        send(1'b1, 1'b0, 1'b0, seg_of(9));
        tests_run++;
        if ({phase, err_flags, err_irq} !== {3'd1, 5'b00001, 1'b0}) begin
            tests_failed++;
            $display("FAIL lamp_resync_red: got ph=%0d err=%b irq=%b, want ph=1 err=00001 irq=0", phase, err_flags, err_irq);
        end
        for (int i = 1; i < 10; i++) send(1'b1, 1'b0, 1'b0, seg_of(9 - i));
        clr_err = 1'b1;
        send(1'b1, 1'b1, 1'b0, seg_of(0));
        clr_err = 1'b0;
        tests_run++;
        if ({phase, err_flags} !== {3'd2, 5'b00000}) begin
            tests_failed++;
            $display("FAIL resync_exit_clear: got ph=%0d err=%b, want ph=2 err=00000", phase, err_flags);
        end
        hold(1'b1, 1'b1, 1'b0, 3);
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        tests_run++;
        if ({phase, err_flags} !== {3'd3, 5'b00000}) begin
            tests_failed++;
            $display("FAIL resync_next_phase: got ph=%0d err=%b, want ph=3 err=00000", phase, err_flags);
        end
    endtask

    task automatic test_duration();
        hold(1'b0, 1'b0, 1'b1, 5);
        send(1'b0, 1'b0, 1'b0, seg_of(0));
        tests_run++;
        if ({phase, err_flags, err_irq} !== {3'd4, 5'b00100, 1'b1}) begin
            tests_failed++;
            $display("FAIL green_short: got ph=%0d err=%b irq=%b, want ph=4 err=00100 irq=1", phase, err_flags, err_irq);
        end
        clr_err = 1'b1;
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        clr_err = 1'b0;
        for (int i = 2; i < 6; i++) send(1'b0, 1'b0, i[0], seg_of(0));
        hold(1'b0, 1'b1, 1'b0, 4);
        red_count(10);
        hold(1'b1, 1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 1'b1, 10);
        tests_run++;
        if (err_flags !== 5'b00000) begin
            tests_failed++;
            $display("FAIL green_10_ok: got err=%b, want 00000", err_flags);
        end
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        tests_run++;
        if ({err_flags, err_irq} !== {5'b00100, 1'b1}) begin
            tests_failed++;
            $display("FAIL green_long: got err=%b irq=%b, want err=00100 irq=1", err_flags, err_irq);
        end
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        tests_run++;
        if ({err_flags, err_irq} !== {5'b00100, 1'b0}) begin
            tests_failed++;
            $display("FAIL green_long_once: got err=%b irq=%b, want err=00100 irq=0", err_flags, err_irq);
        end
        send(1'b0, 1'b0, 1'b0, seg_of(0));
        tests_run++;
        if ({phase, err_irq} !== {3'd4, 1'b0}) begin
            tests_failed++;
            $display("FAIL green_long_exit: got ph=%0d irq=%b, want ph=4 irq=0", phase, err_irq);
        end
        clr_err = 1'b1;
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        clr_err = 1'b0;
        for (int i = 2; i < 6; i++) send(1'b0, 1'b0, i[0], seg_of(0));
        hold(1'b0, 1'b1, 1'b0, 4);
        tests_run++;
        if ({phase, err_flags} !== {3'd5, 5'b00000}) begin
            tests_failed++;
            $display("FAIL duration_recover: got ph=%0d err=%b, want ph=5 err=00000", phase, err_flags);
        end
    endtask

    task automatic test_digit();
        red_count(3);
        send(1'b1, 1'b0, 1'b0, seg_of(5));
        tests_run++;
        if ({err_flags, digit, seg_valid} !== {5'b10000, 4'd5, 1'b1}) begin
            tests_failed++;
            $display("FAIL digit_mismatch: got err=%b dig=%0d sv=%b, want err=10000 dig=5 sv=1", err_flags, digit, seg_valid);
        end
        send(1'b1, 1'b0, 1'b0, 7'b0000000);
        tests_run++;
        if ({digit, seg_valid, err_irq} !== {4'd5, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL digit_invalid: got dig=%0d sv=%b irq=%b, want dig=5 sv=0 irq=1", digit, seg_valid, err_irq);
        end
        for (int i = 5; i < 10; i++) send(1'b1, 1'b0, 1'b0, seg_of(9 - i));
        tests_run++;
        if ({err_flags, err_irq, digit} !== {5'b10000, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL digit_resume: got err=%b irq=%b dig=%0d, want err=10000 irq=0 dig=0", err_flags, err_irq, digit);
        end
        hold(1'b1, 1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 1'b1, 10);
    endtask

    task automatic test_blink();
        send(1'b0, 1'b0, 1'b0, seg_of(0));
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        tests_run++;
        if ({phase, err_flags} !== {3'd4, 5'b10000}) begin
            tests_failed++;
            $display("FAIL blink_ok: got ph=%0d err=%b, want ph=4 err=10000", phase, err_flags);
        end
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        tests_run++;
        if ({err_flags, err_irq} !== {5'b11000, 1'b1}) begin
            tests_failed++;
            $display("FAIL blink_repeat: got err=%b irq=%b, want err=11000 irq=1", err_flags, err_irq);
        end
        clr_err = 1'b1;
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        clr_err = 1'b0;
        tests_run++;
        if (err_flags !== 5'b01000) begin
            tests_failed++;
            $display("FAIL blink_clr_collide: got err=%b, want 01000", err_flags);
        end
        send(1'b0, 1'b0, 1'b0, seg_of(0));
        send(1'b0, 1'b0, 1'b1, seg_of(0));
        hold(1'b0, 1'b1, 1'b0, 4);
        tests_run++;
        if ({phase, err_flags} !== {3'd5, 5'b01000}) begin
            tests_failed++;
            $display("FAIL blink_exit: got ph=%0d err=%b, want ph=5 err=01000", phase, err_flags);
        end
    endtask

    task automatic test_reset_mid();
        red_count(5);
        tests_run++;
        if ({phase, cycles} !== {3'd1, 8'd4}) begin
            tests_failed++;
            $display("FAIL pre_reset: got ph=%0d cyc=%0d, want ph=1 cyc=4", phase, cycles);
        end
        rst = 1'b1;
        #2;
        tests_run++;
        if ({phase, digit, seg_valid, err_flags, err_irq, cycles} !== 22'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got ph=%0d dig=%0d sv=%b err=%b irq=%b cyc=%0d, want all 0",
                     phase, digit, seg_valid, err_flags, err_irq, cycles);
        end
        rst = 1'b0;
        send(1'b0, 1'b1, 1'b0, seg_of(0));
        tests_run++;
        if ({phase, err_flags} !== {3'd0, 5'b01000}) begin
            tests_failed++;
            $display("FAIL idle_first_lit: got ph=%0d err=%b, want ph=0 err=01000", phase, err_flags);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b0, 1'b0, 1'b0, seg_of(0));
        red_count(10);
        for (int k = 1; k <= 256; k++) begin
            tail();
            red_count(10);
            if (k == 255) begin
                tests_run++;
                if (cycles !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL cycles_255: got %0d, want 255", cycles);
                end
            end
        end
        tests_run++;
        if ({phase, err_flags, cycles} !== {3'd1, 5'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL cycles_wrap: got ph=%0d err=%b cyc=%0d, want ph=1 err=00000 cyc=0", phase, err_flags, cycles);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lamp_combo();
        test_duration();
        test_digit();
        test_blink();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
